// File: rtl/wb_ram.sv
// wb_ram: Wishbone B4 classic-cycle RAM responder.
// Word-organised 32-bit storage with byte-lane writes, a programmable number of
// wait states before the response, and base-address decode.
// Optional feature macro: WB_RAM_ERR_EN. When it is defined, out-of-range requests
// complete with err and have no effect. When it is undefined, addresses alias
// modulo DEPTH and err stays low.
//
// Handshake: a request is valid when i_bus_cyc & i_bus_stb are high. It is
// accepted only while the FSM is IDLE; the accepted request is latched. Exactly
// one of o_bus_ack / o_bus_err pulses for one cycle per accepted request, unless
// the master drops i_bus_cyc during the wait phase. In that case the request is
// abandoned silently. The master must drop stb after the response, or the
// following IDLE cycle takes it as a new request.
module wb_ram #(
  parameter int          XLEN        = 32,
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_bus_cyc,
  input  logic            i_bus_stb,
  input  logic            i_bus_we,
  input  logic [3:0]      i_bus_sel,
  input  logic [XLEN-1:0] i_bus_adr,
  input  logic [XLEN-1:0] i_bus_dat_w,
  output logic [XLEN-1:0] o_bus_dat_r,
  output logic            o_bus_ack,
  output logic            o_bus_err,
  output logic [1:0]      o_dbg_state
);

  localparam int            LP_IW   = $clog2(DEPTH);
  localparam logic [3:0]    LP_WS   = 4'(WAIT_STATES);
  localparam logic [XLEN:0] LP_SPAN = (XLEN+1)'(DEPTH) << 2;
  localparam logic [XLEN:0] LP_BASE = {1'b0, BASE_ADDR};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [3:0]      r_sel;
  logic [XLEN-1:0] r_adr;
  logic [XLEN-1:0] r_dat_w;
  logic [XLEN-1:0] r_dat_r;
  logic            r_ack;
  logic            r_err;

  logic [XLEN-1:0] r_mem [DEPTH];

  logic             w_req;
  logic             w_in_idle;
  logic             w_issue_now;
  logic             w_finish_wait;
  logic             w_commit;
  logic             w_acc_we;
  logic [3:0]       w_acc_sel;
  logic [XLEN-1:0]  w_acc_adr;
  logic [XLEN-1:0]  w_acc_dat_w;
  logic [XLEN:0]    w_diff;
  logic [LP_IW-1:0] w_idx;
  logic             w_in_range;
  logic             w_mem_we;
  logic             w_unused_bits;

  assign w_req     = i_bus_cyc & i_bus_stb;
  assign w_in_idle = (r_state == IDLE);

  // With zero wait states the access happens on the same edge that latches the
  // request, so the operands come straight from the bus; otherwise from the latch.
  assign w_acc_we    = w_in_idle ? i_bus_we    : r_we;
  assign w_acc_sel   = w_in_idle ? i_bus_sel   : r_sel;
  assign w_acc_adr   = w_in_idle ? i_bus_adr   : r_adr;
  assign w_acc_dat_w = w_in_idle ? i_bus_dat_w : r_dat_w;

  // The subtraction is one bit wider than the address. An address below the base
  // then wraps to a value with the top bit set, so one unsigned compare against
  // the span covers both ends of the window.
  assign w_diff = {1'b0, w_acc_adr} - LP_BASE;
  assign w_idx  = w_diff[LP_IW+1:2];

`ifdef WB_RAM_ERR_EN
  assign w_in_range = (w_diff < LP_SPAN);
`else
  assign w_in_range = 1'b1;
`endif

  // Byte offset and high address bits only matter for range decode.
  assign w_unused_bits = ^{w_diff[1:0], w_diff[XLEN:LP_IW+2]};

  assign w_issue_now   = w_in_idle & w_req & (WAIT_STATES == 0);
  assign w_finish_wait = (r_state == WAIT) & i_bus_cyc & (r_cnt == 4'd1);
  // A reset on the commit edge abandons the access.
  assign w_commit      = ~rst & (w_issue_now | w_finish_wait);
  assign w_mem_we      = w_commit & w_acc_we & w_in_range;

  // Storage write port: only the selected byte lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_sel[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_acc_dat_w[8*i +: 8];
        end
      end
    end
  end

  // Request FSM: latch, count wait states, issue a one-cycle registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_sel   <= 4'd0;
      r_adr   <= '0;
      r_dat_w <= '0;
      r_dat_r <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_we    <= i_bus_we;
            r_sel   <= i_bus_sel;
            r_adr   <= i_bus_adr;
            r_dat_w <= i_bus_dat_w;
            if (WAIT_STATES == 0) begin
              if (w_in_range) begin
                r_ack <= 1'b1;
                if (!w_acc_we) begin
                  r_dat_r <= r_mem[w_idx];
                end
              end else begin
                r_err <= 1'b1;
              end
              r_state <= RESP;
            end else begin
              r_cnt   <= LP_WS;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!i_bus_cyc) begin
            r_cnt   <= 4'd0;
            r_state <= IDLE;
          end else if (r_cnt == 4'd1) begin
            if (w_in_range) begin
              r_ack <= 1'b1;
              if (!w_acc_we) begin
                r_dat_r <= r_mem[w_idx];
              end
            end else begin
              r_err <= 1'b1;
            end
            r_cnt   <= 4'd0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_bus_dat_r = r_dat_r;
  assign o_bus_ack   = r_ack;
`ifdef WB_RAM_ERR_EN
  assign o_bus_err   = r_err;
`else
  assign o_bus_err   = 1'b0;
`endif
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_ram.sv
// tb_wb_ram: bench for wb_ram. Instance 0 has zero wait states; instance 1 has
// three. Both share the base address 0x1000 and a depth of 256 words.
module tb_wb_ram;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] adr   [2];
  logic [31:0] dat_w [2];
  logic [31:0] dat_r [2];
  logic        ack   [2];
  logic        err   [2];
  logic [1:0]  dbg   [2];

  logic [31:0] exp_q[$];
  logic [31:0] mdl0[int];
  int          n_cmp = 0;
  int          n_mis = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  wb_ram #(.XLEN(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ram0 (
    .clk(clk), .rst(rst),
    .i_bus_cyc(cyc[0]), .i_bus_stb(stb[0]), .i_bus_we(we[0]), .i_bus_sel(sel[0]),
    .i_bus_adr(adr[0]), .i_bus_dat_w(dat_w[0]),
    .o_bus_dat_r(dat_r[0]), .o_bus_ack(ack[0]), .o_bus_err(err[0]),
    .o_dbg_state(dbg[0])
  );

  wb_ram #(.XLEN(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ram3 (
    .clk(clk), .rst(rst),
    .i_bus_cyc(cyc[1]), .i_bus_stb(stb[1]), .i_bus_we(we[1]), .i_bus_sel(sel[1]),
    .i_bus_adr(adr[1]), .i_bus_dat_w(dat_w[1]),
    .o_bus_dat_r(dat_r[1]), .o_bus_ack(ack[1]), .o_bus_err(err[1]),
    .o_dbg_state(dbg[1])
  );

  // ---------------- driver tasks ----------------
  // One classic cycle: drive on a falling edge, then count falling edges until a
  // response appears (lat = cycles after the request was first sampled).
  task automatic do_xfer(input int d, input logic we_i, input logic [3:0] sel_i,
                         input logic [31:0] adr_i, input logic [31:0] dat_i,
                         output int lat, output logic got_ack, output logic got_err,
                         output logic [31:0] rdata, output logic resp_after);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = we_i;
    sel[d] = sel_i; adr[d] = adr_i; dat_w[d] = dat_i;
    lat = -1; got_ack = 1'b0; got_err = 1'b0; rdata = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ack[d] || err[d]) begin
        lat = c; got_ack = ack[d]; got_err = err[d]; rdata = dat_r[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(negedge clk);
    resp_after = ack[d] | err[d];
  endtask

  task automatic bus_idle();
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      sel[d] = 4'h0; adr[d] = '0; dat_w[d] = '0;
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] dv);
    int          k;
    logic [31:0] w;
    k = int'((a - BASE) >> 2);
    w = mdl0.exists(k) ? mdl0[k] : 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = dv[8*i +: 8];
    mdl0[k] = w;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (ack[d] !== 1'b0) begin n_mis++; $display("FAIL reset_ack[%0d] got %b want 0", d, ack[d]); end
      n_cmp++; if (err[d] !== 1'b0) begin n_mis++; $display("FAIL reset_err[%0d] got %b want 0", d, err[d]); end
      n_cmp++; if (dat_r[d] !== 32'h0) begin n_mis++; $display("FAIL reset_dat_r[%0d] got %h want 0", d, dat_r[d]); end
      n_cmp++; if (dbg[d] !== 2'd0) begin n_mis++; $display("FAIL reset_state[%0d] got %0d want 0", d, dbg[d]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat; logic ga, ge, ra; logic [31:0] rd, e;
    do_xfer(0, 1'b1, 4'hF, BASE + 32'd8, 32'hDEADBEEF, lat, ga, ge, rd, ra);
    model_write(BASE + 32'd8, 4'hF, 32'hDEADBEEF);
    n_cmp++; if (lat !== 1) begin n_mis++; $display("FAIL wr_latency got %0d want 1", lat); end
    n_cmp++; if (ga !== 1'b1 || ge !== 1'b0) begin n_mis++; $display("FAIL wr_ack got ack=%b err=%b want 1/0", ga, ge); end
    exp_q.push_back(32'hDEADBEEF);
    do_xfer(0, 1'b0, 4'hF, BASE + 32'd8, 32'h0, lat, ga, ge, rd, ra);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 1) begin n_mis++; $display("FAIL rd_latency got %0d want 1", lat); end
    n_cmp++; if (rd !== e) begin n_mis++; $display("FAIL rd_data got %h want %h", rd, e); end
    n_cmp++; if (ra !== 1'b0) begin n_mis++; $display("FAIL rd_ack_width got %b want 0", ra); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic ga, ge, ra; logic [31:0] rd, e;
    do_xfer(0, 1'b1, 4'hF, BASE + 32'h10, 32'h11223344, lat, ga, ge, rd, ra);
    do_xfer(0, 1'b1, 4'b0101, BASE + 32'h10, 32'hAABBCCDD, lat, ga, ge, rd, ra);
    exp_q.push_back(32'h11BB33DD);
    do_xfer(0, 1'b0, 4'h0, BASE + 32'h10, 32'h0, lat, ga, ge, rd, ra);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_mis++; $display("FAIL lanes_data got %h want %h", rd, e); end
    do_xfer(0, 1'b1, 4'h0, BASE + 32'h10, 32'hFFFFFFFF, lat, ga, ge, rd, ra);
    n_cmp++; if (ga !== 1'b1 || lat !== 1) begin n_mis++; $display("FAIL sel0_ack got ack=%b lat=%0d want 1/1", ga, lat); end
    exp_q.push_back(32'h11BB33DD);
    do_xfer(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0, lat, ga, ge, rd, ra);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_mis++; $display("FAIL sel0_data got %h want %h", rd, e); end
  endtask

  task automatic test_random_lanes();
    int lat; logic ga, ge, ra; logic [31:0] rd, e, a, dv; logic [3:0] s;
    for (int i = 0; i < 8; i++) begin
      a  = BASE + 32'h100 + 32'(i * 4) + 32'($urandom_range(0, 3));
      dv = $urandom;
      do_xfer(0, 1'b1, 4'hF, a, dv, lat, ga, ge, rd, ra);
      model_write(a, 4'hF, dv);
    end
    for (int i = 0; i < 10; i++) begin
      a  = BASE + 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      dv = $urandom;
      s  = 4'($urandom_range(0, 15));
      do_xfer(0, 1'b1, s, a, dv, lat, ga, ge, rd, ra);
      model_write(a, s, dv);
    end
    for (int i = 0; i < 8; i++) begin
      a = BASE + 32'h100 + 32'(i * 4);
      exp_q.push_back(mdl0[int'((a - BASE) >> 2)]);
      do_xfer(0, 1'b0, 4'($urandom_range(0, 15)), a, 32'h0, lat, ga, ge, rd, ra);
      e = exp_q.pop_front();
      n_cmp++; if (rd !== e) begin n_mis++; $display("FAIL rand_data[%0d] got %h want %h", i, rd, e); end
    end
  endtask

  task automatic test_wait_states();
    int lat; logic ga, ge, ra; logic [31:0] rd, e;
    do_xfer(1, 1'b1, 4'hF, BASE + 32'h40, 32'hCAFE0001, lat, ga, ge, rd, ra);
    n_cmp++; if (lat !== 4 || ga !== 1'b1) begin n_mis++; $display("FAIL ws_wr got lat=%0d ack=%b want 4/1", lat, ga); end
    exp_q.push_back(32'hCAFE0001);
    do_xfer(1, 1'b0, 4'hF, BASE + 32'h40, 32'h0, lat, ga, ge, rd, ra);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 4) begin n_mis++; $display("FAIL ws_rd_latency got %0d want 4", lat); end
    n_cmp++; if (ra !== 1'b0) begin n_mis++; $display("FAIL ws_ack_width got %b want 0", ra); end
    n_cmp++; if (rd !== e) begin n_mis++; $display("FAIL ws_rd_data got %h want %h", rd, e); end
  endtask

  task automatic test_back_to_back();
    int lat; logic ga, ge, ra; logic [31:0] rd, e;
    int c1, c2, nack;
    do_xfer(1, 1'b1, 4'hF, BASE + 32'h44, 32'h0A0A0A0A, lat, ga, ge, rd, ra);
    do_xfer(1, 1'b1, 4'hF, BASE + 32'h48, 32'h0B0B0B0B, lat, ga, ge, rd, ra);
    exp_q.push_back(32'h0A0A0A0A);
    exp_q.push_back(32'h0B0B0B0B);
    c1 = -1; c2 = -1; nack = 0;
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; adr[1] = BASE + 32'h44;
    for (int c = 1; c <= 40 && nack < 2; c++) begin
      @(negedge clk);
      if (ack[1]) begin
        e = exp_q.pop_front();
        n_cmp++; if (dat_r[1] !== e) begin n_mis++; $display("FAIL b2b_data[%0d] got %h want %h", nack, dat_r[1], e); end
        if (nack == 0) begin c1 = c; adr[1] = BASE + 32'h48; end
        else c2 = c;
        nack++;
      end
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    n_cmp++; if (c1 !== 4) begin n_mis++; $display("FAIL b2b_first got %0d want 4", c1); end
    n_cmp++; if (c2 - c1 !== 5) begin n_mis++; $display("FAIL b2b_spacing got %0d want 5", c2 - c1); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int lat; logic ga, ge, ra; logic [31:0] rd, e;
    int nresp;
    do_xfer(1, 1'b1, 4'hF, BASE + 32'h50, 32'h01D01D00, lat, ga, ge, rd, ra);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
    adr[1] = BASE + 32'h50; dat_w[1] = 32'hBAD0BAD0;
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    nresp = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[1] || err[1]) nresp++;
    end
    n_cmp++; if (nresp !== 0) begin n_mis++; $display("FAIL abort_resp got %0d want 0", nresp); end
    exp_q.push_back(32'h01D01D00);
    do_xfer(1, 1'b0, 4'hF, BASE + 32'h50, 32'h0, lat, ga, ge, rd, ra);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_mis++; $display("FAIL abort_data got %h want %h", rd, e); end
  endtask

  task automatic test_range();
    int lat; logic ga, ge, ra; logic [31:0] rd, e;
    do_xfer(0, 1'b1, 4'hF, BASE, 32'h0BADF00D, lat, ga, ge, rd, ra);
    do_xfer(0, 1'b0, 4'hF, BASE + 32'd8, 32'h0, lat, ga, ge, rd, ra);
`ifdef WB_RAM_ERR_EN
    exp_q.push_back(32'hDEADBEEF);
    do_xfer(0, 1'b0, 4'hF, BASE + 32'(DEPTH * 4), 32'h0, lat, ga, ge, rd, ra);
    e = exp_q.pop_front();
    n_cmp++; if (ge !== 1'b1 || ga !== 1'b0) begin n_mis++; $display("FAIL range_err got ack=%b err=%b want 0/1", ga, ge); end
    n_cmp++; if (lat !== 1) begin n_mis++; $display("FAIL range_latency got %0d want 1", lat); end
    n_cmp++; if (rd !== e) begin n_mis++; $display("FAIL range_dat_r got %h want %h", rd, e); end
`else
    exp_q.push_back(32'h0BADF00D);
    do_xfer(0, 1'b0, 4'hF, BASE + 32'(DEPTH * 4), 32'h0, lat, ga, ge, rd, ra);
    e = exp_q.pop_front();
    n_cmp++; if (ga !== 1'b1 || ge !== 1'b0) begin n_mis++; $display("FAIL range_ack got ack=%b err=%b want 1/0", ga, ge); end
    n_cmp++; if (lat !== 1) begin n_mis++; $display("FAIL range_latency got %0d want 1", lat); end
    n_cmp++; if (rd !== e) begin n_mis++; $display("FAIL range_alias got %h want %h", rd, e); end
`endif
  endtask

  task automatic test_reset_in_wait();
    int lat; logic ga, ge, ra; logic [31:0] rd, e;
    do_xfer(1, 1'b1, 4'hF, BASE + 32'h60, 32'h55AA55AA, lat, ga, ge, rd, ra);
    exp_q.push_back(32'h55AA55AA);
    do_xfer(1, 1'b0, 4'hF, BASE + 32'h60, 32'h0, lat, ga, ge, rd, ra);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_mis++; $display("FAIL rstw_pre got %h want %h", rd, e); end
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
    adr[1] = BASE + 32'h60; dat_w[1] = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin n_mis++; $display("FAIL rstw_resp got ack=%b err=%b want 0/0", ack[1], err[1]); end
    n_cmp++; if (dat_r[1] !== 32'h0) begin n_mis++; $display("FAIL rstw_dat_r got %h want 0", dat_r[1]); end
    n_cmp++; if (dbg[1] !== 2'd0) begin n_mis++; $display("FAIL rstw_state got %0d want 0", dbg[1]); end
    rst = 1'b0;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'h55AA55AA);
    do_xfer(1, 1'b0, 4'hF, BASE + 32'h60, 32'h0, lat, ga, ge, rd, ra);
    e = exp_q.pop_front();
    n_cmp++; if (rd !== e) begin n_mis++; $display("FAIL rstw_word got %h want %h", rd, e); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_random_lanes();
    test_wait_states();
    test_back_to_back();
    test_abort();
    test_range();
    test_reset_in_wait();
    n_cmp++; if (exp_q.size() !== 0) begin n_mis++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_ram.md
# wb_ram

Wishbone B4 classic-cycle responder: a word-organised, byte-writable RAM with configurable wait states and address decode. It is the slave end of the core's `instr_bus` and `data_bus` master ports. It provides program and data storage for simulation and FPGA builds, with one instance per port.

## Interface

Parameters:
- `XLEN`, 32: data width in bits; must be 32.
- `DEPTH`, 4096: number of words; must be a power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be `DEPTH*4` aligned.
- `WAIT_STATES`, 0: extra cycles inserted before `ack`/`err`; range 0–15.

Ports (clock and reset first):
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `bus`  `wishbone.SLAVE`  —  fields used:
  - inputs `cyc`, `stb`, `we`, `sel[3:0]`, `adr[XLEN-1:0]` (byte address), `dat_w[XLEN-1:0]`
  - outputs `dat_r[XLEN-1:0]`, `ack`, `err`

## Operation

- FSM states: `IDLE`, `WAIT`, `RESP`.
- `IDLE`:
  - On `cyc & stb`, latch `adr`, `we`, `sel`, `dat_w`.
  - If `WAIT_STATES==0`, perform the access and go to `RESP`.
  - Otherwise load a counter with `WAIT_STATES` and go to `WAIT`.
- `WAIT`:
  - Decrement the counter each cycle.
  - On the edge where the counter is 1, perform the access and go to `RESP`.
  - If `cyc` is low in any `WAIT` cycle, go to `IDLE`. No access occurs, and no `ack`/`err` is issued.
- `RESP`:
  - Assert `ack` (or `err`) for exactly one cycle, then go unconditionally to `IDLE`.
  - `stb` still high in the following `IDLE` cycle is sampled as a new request.
- Access rules, using latched values only:
  - Word index = `(adr - BASE_ADDR) >> 2` over `log2(DEPTH)` bits; `adr[1:0]` is ignored.
  - Write: for each `sel[i]`, store `dat_w[8i+7:8i]` into byte i of the word. Unselected bytes are unchanged. `sel==0` is a legal no-op write and still gets `ack`.
  - Read: capture the full word into `dat_r` regardless of `sel`. `dat_r` holds its value until the next completed read; writes do not change `dat_r`.
- Range: an address is in range iff `BASE_ADDR <= adr < BASE_ADDR + DEPTH*4`. Out-of-range handling is set by configuration.
- Reset values: state `IDLE`, `ack=0`, `err=0`, `dat_r=0`, counter 0.
  - RAM contents are not reset.
  - Reset during `WAIT` abandons the request with no write.
  - Reset during `RESP` drops `ack` on the next cycle; the write has already committed.

## Timing

- Request first seen in `IDLE` in cycle N → `ack`/`err` high in cycle N+1+`WAIT_STATES`, for one cycle only.
- Access commits on the edge entering `RESP`. `dat_r` is valid in the `ack` cycle.
- Throughput with `stb` held high: one access per 2+`WAIT_STATES` cycles.
- `ack` and `err` are registered and mutually exclusive. Neither ever asserts without a preceding `cyc & stb`.
- Read after write to the same word in the next transaction returns the new data. There is no hazard, because accesses are serialised.

## Configuration

- Macro: `WB_RAM_ERR_EN`.
- Defined: an out-of-range request follows the same state and timing path, but asserts `err` instead of `ack`. There is no write, and `dat_r` is unchanged.
- Undefined: out-of-range addresses alias modulo `DEPTH` (word index from the low bits as above) and always complete with `ack`. `err` is tied to 0.

## Test plan

- **Write/read, `WAIT_STATES=0`:**
  - Write `32'hDEADBEEF`, `sel=4'hF`, to `BASE_ADDR+8` → `ack` in cycle N+1.
  - Read the same address → `ack` in N+1, `dat_r=32'hDEADBEEF`.
- **Byte lanes:**
  - After writing `32'h11223344`, write `32'hAABBCCDD` with `sel=4'b0101` → read returns `32'h11BB33DD`.
  - A `sel=0` write → `ack`, word unchanged.
- **Wait states:**
  - With `WAIT_STATES=3`, a read first seen in cycle N → `ack` only in N+4, one cycle wide.
  - Back-to-back reads with `stb` held high → `ack`s 5 cycles apart.
- **Abort:** with `WAIT_STATES=3`, a write with `cyc` dropped after 1 cycle → no `ack`/`err`, and a later read shows the old value.
- **Range:**
  - With `WB_RAM_ERR_EN`, read `BASE_ADDR+DEPTH*4` → `err` in N+1, `ack=0`, `dat_r` unchanged.
  - Without the macro, the same access → `ack`, aliasing word 0.
- **Reset:** assert `rst` during `WAIT` of a write → next cycle `ack=0`, `err=0`, `dat_r=0`, and the target word is unmodified.
